// File: rtl/ddr_calib_sequencer.sv
// Sequential DDR4 controller bring-up: per channel reset, calibration wait with
// timeout and bounded retries, then a post-bring-up health monitor.
module ddr_calib_sequencer #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned RST_CYCLES     = 256,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned MAX_RETRY      = 2,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                                          aclk,
  input  logic                                          aresetn,
  input  logic                                          start,
  input  logic [NUM_CH-1:0]                             calib_done_i,
  output logic [NUM_CH-1:0]                             mc_rst_o,
  output logic [NUM_CH-1:0]                             ch_ready,
  output logic [NUM_CH-1:0]                             ch_fail,
  output logic [NUM_CH-1:0]                             calib_lost,
  output logic [$clog2((NUM_CH > 1) ? NUM_CH : 2)-1:0] cur_ch,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          all_ready
);

  localparam int unsigned CW      = $clog2((NUM_CH > 1) ? NUM_CH : 2);
  localparam int unsigned CNT_MAX = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNTW    = $clog2((CNT_MAX > 1) ? CNT_MAX : 2);

  localparam logic [CNTW-1:0] RST_LAST = CNTW'(RST_CYCLES - 1);
  localparam logic [CNTW-1:0] TO_LAST  = CNTW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      RETRIES  = 4'(MAX_RETRY);
  localparam logic [CW-1:0]   LAST_CH  = CW'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_WAIT_CAL,
    S_NEXT,
    S_DONE
  } state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [3:0]      retry;

  assign all_ready = done & (&ch_ready);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      retry      <= '0;
      mc_rst_o   <= '1;
      ch_ready   <= '0;
      ch_fail    <= '0;
      calib_lost <= '0;
      cur_ch     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start || (state == S_IDLE && AUTO_START)) begin
            ch_ready   <= '0;
            ch_fail    <= '0;
            calib_lost <= '0;
            mc_rst_o   <= '1;
            cur_ch     <= '0;
            retry      <= '0;
            cnt        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            state      <= S_RESET;
          end else if (state == S_DONE) begin
            // Health monitor: a ready channel whose calibration drops is demoted for good.
            calib_lost <= calib_lost | (ch_ready & ~calib_done_i);
            ch_ready   <= ch_ready & calib_done_i;
          end
        end

        S_RESET: begin
          if (cnt == RST_LAST) begin
            cnt              <= '0;
            mc_rst_o[cur_ch] <= 1'b0;
            state            <= S_WAIT_CAL;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end

        S_WAIT_CAL: begin
          if (calib_done_i[cur_ch]) begin
            ch_ready[cur_ch] <= 1'b1;
            cnt              <= '0;
            state            <= S_NEXT;
          end else if (cnt == TO_LAST) begin
            cnt <= '0;
            // Reset is re-raised on the transition edge so a retry holds it exactly RST_CYCLES.
            mc_rst_o[cur_ch] <= 1'b1;
            if (retry < RETRIES) begin
              retry <= retry + 4'd1;
              state <= S_RESET;
            end else begin
              ch_fail[cur_ch] <= 1'b1;
              state           <= S_NEXT;
            end
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end

        S_NEXT: begin
          retry <= '0;
          if (cur_ch == LAST_CH) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cur_ch <= cur_ch + CW'(1);
            state  <= S_RESET;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_calib_sequencer.sv
// Bench for ddr_calib_sequencer: a timeline model derived from per-attempt
// calibration delays predicts every output on every cycle.
module tb_ddr_calib_sequencer;
  localparam int NCH   = 4;
  localparam int RSTC  = 8;
  localparam int TOC   = 64;
  localparam int MR    = 2;
  localparam int NEVER = 100000;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic           start;
  logic [NCH-1:0] calib_done_i;
  logic [NCH-1:0] mc_rst_o, ch_ready, ch_fail, calib_lost;
  logic [1:0]     cur_ch;
  logic           busy, done, all_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Cycle (within an attempt's calibration window) at which calib_done rises.
  int dly [NCH][MR+1];

  int             busy_cnt, rst_cur_hi;
  int             falls [NCH];
  bit             reset_hit;
  logic [NCH-1:0] first_rst, first_ready, first_lost;
  logic           first_done;
  logic [NCH-1:0] last_rst, last_ready, last_fail, last_lost;
  logic           last_all;

  ddr_calib_sequencer #(
    .NUM_CH(NCH), .RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TOC), .MAX_RETRY(MR), .AUTO_START(1'b1)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .calib_done_i(calib_done_i),
    .mc_rst_o(mc_rst_o), .ch_ready(ch_ready), .ch_fail(ch_fail), .calib_lost(calib_lost),
    .cur_ch(cur_ch), .busy(busy), .done(done), .all_ready(all_ready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int             ch;
    int             att;
    int             j;
    bit             in_wait;
    bit             done;
    logic [NCH-1:0] mrst;
    logic [NCH-1:0] rdy;
    logic [NCH-1:0] fl;
  } exp_t;

  // Walk the bring-up timeline: each attempt is RSTC reset cycles plus a wait
  // window, each channel ends with one hand-over cycle; s counts from the first reset cycle.
  function automatic exp_t model_at(input int s);
    exp_t e;
    int   pos = 0;
    e.mrst = '1; e.rdy = '0; e.fl = '0;
    e.ch = 0; e.att = 0; e.j = 0; e.in_wait = 0; e.done = 0;
    for (int c = 0; c < NCH; c++) begin
      bit passed = 0;
      e.ch = c;
      for (int a = 0; a <= MR; a++) begin
        int w = (dly[c][a] < TOC) ? dly[c][a] + 1 : TOC;
        e.att = a;
        if (s < pos + RSTC) return e;
        e.mrst[c] = 1'b0;
        if (s < pos + RSTC + w) begin
          e.in_wait = 1;
          e.j = s - pos - RSTC;
          return e;
        end
        pos += RSTC + w;
        if (dly[c][a] < TOC) begin
          passed = 1;
          break;
        end
        e.mrst[c] = 1'b1;
      end
      if (passed) e.rdy[c] = 1'b1;
      else        e.fl[c]  = 1'b1;
      if (s == pos) return e;
      pos++;
    end
    e.ch = NCH - 1;
    e.done = 1;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_mc_rst_o"},   32'(mc_rst_o),   32'hF);
    chk({pfx, "_ch_ready"},   32'(ch_ready),   32'h0);
    chk({pfx, "_ch_fail"},    32'(ch_fail),    32'h0);
    chk({pfx, "_calib_lost"}, 32'(calib_lost), 32'h0);
    chk({pfx, "_cur_ch"},     32'(cur_ch),     32'h0);
    chk({pfx, "_busy"},       32'(busy),       32'h0);
    chk({pfx, "_done"},       32'(done),       32'h0);
    chk({pfx, "_all_ready"},  32'(all_ready),  32'h0);
  endtask

  task automatic set_plan_all(input int d);
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a <= MR; a++) dly[c][a] = d;
  endtask

  task automatic set_plan_random();
    for (int c = 0; c < NCH; c++)
      for (int a = 0; a <= MR; a++) begin
        int r = int'($urandom_range(0, 9));
        if (r < 3)       dly[c][a] = NEVER;
        else if (r == 3) dly[c][a] = TOC - 1;
        else if (r == 4) dly[c][a] = 0;
        else             dly[c][a] = int'($urandom_range(0, TOC - 1));
      end
  endtask

  // One bring-up run; the DUT must enter its first reset cycle at the next clock edge.
  task automatic run_seq(input int done_cycles, input int drop_ch, input bit rand_drop,
                         input bit busy_start, input bit do_reset, input bit restart);
    exp_t           e;
    int             s = 0;
    bit             in_done = 0;
    int             done_at = 0;
    int             start_at = busy_start ? int'($urandom_range(0, 60)) : -1;
    logic [NCH-1:0] m_ready = '0, m_lost = '0, prev_rst = '1;
    logic [NCH-1:0] cin, exp_ready, exp_lost;
    busy_cnt = 0; rst_cur_hi = 0; reset_hit = 0;
    foreach (falls[c]) falls[c] = 0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge aclk); #1;
      e = model_at(s);
      if (e.done && !in_done) begin
        in_done = 1; done_at = s; m_ready = e.rdy; m_lost = '0;
      end
      exp_ready = in_done ? m_ready : e.rdy;
      exp_lost  = in_done ? m_lost : '0;
      chk("mc_rst_o",   32'(mc_rst_o),   32'(e.mrst));
      chk("ch_ready",   32'(ch_ready),   32'(exp_ready));
      chk("ch_fail",    32'(ch_fail),    32'(e.fl));
      chk("calib_lost", 32'(calib_lost), 32'(exp_lost));
      chk("cur_ch",     32'(cur_ch),     32'(e.ch));
      chk("busy",       32'(busy),       32'(!e.done));
      chk("done",       32'(done),       32'(e.done));
      chk("all_ready",  32'(all_ready),  32'(e.done && (&exp_ready)));
      if (s == 0) begin
        first_rst = mc_rst_o; first_ready = ch_ready; first_lost = calib_lost; first_done = done;
      end
      if (busy) busy_cnt++;
      if (busy && mc_rst_o[cur_ch]) rst_cur_hi++;
      for (int c = 0; c < NCH; c++) if (prev_rst[c] && !mc_rst_o[c]) falls[c]++;
      prev_rst = mc_rst_o;
      last_rst = mc_rst_o; last_ready = ch_ready; last_fail = ch_fail;
      last_lost = calib_lost; last_all = all_ready;

      if (do_reset && e.in_wait && e.ch == 1 && e.j == 5) begin
        #3 aresetn = 1'b0;
        #1 check_reset_vals("async_rst");
        @(posedge aclk); #1 check_reset_vals("held_rst");
        start = 1'b0;
        reset_hit = 1;
        #2 aresetn = 1'b1;
        return;
      end

      start = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        logic junk = 1'($urandom_range(0, 1));
        if (in_done) begin
          if (e.rdy[c]) begin
            cin[c] = 1'b1;
            if (c == drop_ch && s - done_at == 2) cin[c] = 1'b0;
            if (rand_drop && $urandom_range(0, 7) == 0) cin[c] = 1'b0;
          end else cin[c] = junk;
        end else if (c < e.ch || (c == e.ch && !e.in_wait)) cin[c] = e.rdy[c] ? 1'b1 : junk;
        else if (c == e.ch) cin[c] = (e.j >= dly[c][e.att]);
        else cin[c] = junk;
      end
      calib_done_i = cin;
      if (!in_done && s == start_at) start = 1'b1;
      if (in_done && s - done_at == done_cycles - 1) begin
        if (restart) start = 1'b1;
        return;
      end
      if (in_done) begin
        m_lost  = m_lost | (m_ready & ~cin);
        m_ready = m_ready & cin;
      end
      s++;
    end
    n_checks++;
    n_errors++;
    $display("FAIL run_bound: sequence did not finish within 4000 cycles");
  endtask

  initial begin
    aresetn = 1'b0; start = 1'b0; calib_done_i = '0;
    repeat (3) @(posedge aclk);
    #1 check_reset_vals("por");
    #3 aresetn = 1'b1;

    // Nominal bring-up
    set_plan_all(10);
    run_seq(4, -1, 0, 0, 0, 1);
    chk("s1_busy_cycles", 32'(busy_cnt), 32'd80);
    chk("s1_rst_hold", 32'(rst_cur_hi), 32'd32);
    for (int c = 0; c < NCH; c++) chk("s1_rst_falls", 32'(falls[c]), 32'd1);
    chk("s1_ready", 32'(last_ready), 32'hF);
    chk("s1_all_ready", 32'(last_all), 32'h1);
    chk("s1_fail", 32'(last_fail), 32'h0);

    // Channel 1 passes on its third attempt
    set_plan_all(10);
    dly[1][0] = NEVER; dly[1][1] = NEVER; dly[1][2] = 5;
    run_seq(4, -1, 0, 0, 0, 1);
    chk("s2_rst1_pulses", 32'(falls[1]), 32'd3);
    chk("s2_rst_hold", 32'(rst_cur_hi), 32'd48);
    chk("s2_busy_cycles", 32'(busy_cnt), 32'd219);
    chk("s2_ready", 32'(last_ready), 32'hF);
    chk("s2_fail", 32'(last_fail), 32'h0);

    // Channel 2 never calibrates
    set_plan_all(10);
    for (int a = 0; a <= MR; a++) dly[2][a] = NEVER;
    run_seq(4, -1, 0, 0, 0, 1);
    chk("s3_busy_cycles", 32'(busy_cnt), 32'd277);
    chk("s3_rst2_pulses", 32'(falls[2]), 32'd3);
    chk("s3_fail", 32'(last_fail), 32'h4);
    chk("s3_ready", 32'(last_ready), 32'hB);
    chk("s3_mc_rst", 32'(last_rst), 32'h4);
    chk("s3_all_ready", 32'(last_all), 32'h0);

    // Calibration lost on channel 3 in DONE, plus an ignored start while busy
    set_plan_all(10);
    run_seq(6, 3, 0, 1, 0, 1);
    chk("s4_busy_cycles", 32'(busy_cnt), 32'd80);
    chk("s4_ready", 32'(last_ready), 32'h7);
    chk("s4_lost", 32'(last_lost), 32'h8);
    chk("s4_all_ready", 32'(last_all), 32'h0);

    // Restart from DONE; calibration coincides with the timeout on channel 0
    set_plan_all(10);
    dly[0][0] = TOC - 1;
    run_seq(4, -1, 0, 0, 0, 1);
    chk("s5_first_mc_rst", 32'(first_rst), 32'hF);
    chk("s5_first_ready", 32'(first_ready), 32'h0);
    chk("s5_first_lost", 32'(first_lost), 32'h0);
    chk("s5_first_done", 32'(first_done), 32'h0);
    chk("s7_busy_cycles", 32'(busy_cnt), 32'd133);
    chk("s7_rst0_pulses", 32'(falls[0]), 32'd1);
    chk("s7_ready", 32'(last_ready), 32'hF);

    // Asynchronous reset during channel 1 calibration wait, then auto-restart
    set_plan_all(10);
    run_seq(4, -1, 0, 0, 1, 0);
    chk("s6_reset_hit", 32'(reset_hit), 32'h1);
    run_seq(4, -1, 0, 0, 0, 1);
    chk("s6_busy_cycles", 32'(busy_cnt), 32'd80);
    chk("s6_first_mc_rst", 32'(first_rst), 32'hF);

    for (int r = 0; r < 6; r++) begin
      set_plan_random();
      run_seq(int'($urandom_range(3, 10)), -1, 1, 1, 0, r < 5);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr_calib_sequencer.md
Name: ddr_calib_sequencer

Overview:
- Brings up the shell's DDR4 memory-controller channels one at a time after power-on or on software request.
- For each channel it holds the controller in reset, releases it, then waits for calibration with a timeout and a bounded number of retries.
- It publishes per-channel ready, fail and lost status to the shell's control/status logic and to the XDMA-facing host registers.
- It sits in the shell alongside the four DDR4 controllers, in the shell control clock domain.

Parameters:
- NUM_CH, 4, number of DDR4 channels sequenced (1..8).
- RST_CYCLES, 256, cycles each controller reset is held asserted (>=1).
- TIMEOUT_CYCLES, 2000000, cycles allowed for calibration after reset release (>=1).
- MAX_RETRY, 2, extra reset/calibrate attempts per channel after the first (0..15).
- AUTO_START, 1, if 1 the sequence starts automatically when reset is released.

Ports:
- aclk, in, 1, shell control clock.
- aresetn, in, 1, reset, asynchronous assert, active-low.
- start, in, 1, single-cycle request to rerun the full sequence; honoured only while idle or done.
- calib_done_i, in, NUM_CH, controller calibration-complete flags, already synchronised to aclk upstream.
- mc_rst_o, out, NUM_CH, active-high reset to each controller.
- ch_ready, out, NUM_CH, channel calibrated and currently healthy.
- ch_fail, out, NUM_CH, channel exhausted its retries; sticky until next start.
- calib_lost, out, NUM_CH, calibration dropped after the channel was marked ready; sticky until next start.
- cur_ch, out, clog2(NUM_CH) (min 1), index of the channel being sequenced.
- busy, out, 1, sequence in progress.
- done, out, 1, sequence finished.
- all_ready, out, 1, equals done AND every ch_ready bit set.

Behaviour:
Reset values:
- mc_rst_o all ones; ch_ready, ch_fail, calib_lost all zero.
- cur_ch=0, busy=0, done=0; internal cycle counter=0, retry counter=0.
- State=IDLE.

State machine (registered, all outputs registered):
- IDLE
  - If AUTO_START=1, go to RESET on the first clock after reset release.
  - Otherwise wait for start. On start: clear ch_ready, ch_fail and calib_lost; set cur_ch=0 and retry=0; go to RESET.
  - busy=1 in every state except IDLE and DONE.
- RESET
  - mc_rst_o[cur_ch]=1; counter runs 0..RST_CYCLES-1, so the reset is held exactly RST_CYCLES cycles.
  - Then mc_rst_o[cur_ch]=0, counter=0, go to WAIT_CAL.
- WAIT_CAL
  - calib_done_i[cur_ch] is sampled every cycle, starting with the cycle after entry.
  - If it is 1: ch_ready[cur_ch]=1 on the next edge; go to NEXT.
  - Else, if the counter reaches TIMEOUT_CYCLES-1 with retry<MAX_RETRY: retry++, counter=0, go to RESET.
  - Else, on timeout with retries exhausted: ch_fail[cur_ch]=1, mc_rst_o[cur_ch]=1 (failed controller is parked in reset); go to NEXT.
  - If calibration and timeout occur in the same cycle, calibration wins.
- NEXT
  - retry=0.
  - If cur_ch==NUM_CH-1, go to DONE. Otherwise cur_ch++ and go to RESET.
  - Exactly one cycle.
- DONE
  - done=1, busy=0.
  - Health monitor, every cycle, for each i with ch_ready[i]=1 and calib_done_i[i]=0: clear ch_ready[i] and set calib_lost[i] (sticky).
  - start: mc_rst_o returns to all ones and status is cleared as in IDLE; done=0; go to RESET with cur_ch=0.

Other rules:
- Channels not yet sequenced keep mc_rst_o=1.
- Channels already calibrated keep mc_rst_o=0.
- start while busy is ignored and not queued.
- calib_done_i of channels other than cur_ch is ignored outside DONE.
- aresetn assertion mid-sequence returns every register to its reset value immediately (asynchronous).
- Counter width is clog2(max(RST_CYCLES, TIMEOUT_CYCLES)); no wrap is possible.

Test Plan:
All scenarios use NUM_CH=4, RST_CYCLES=8, TIMEOUT_CYCLES=64, MAX_RETRY=2, AUTO_START=1.
1. Nominal bring-up: each calib_done_i[i] rises 10 cycles after mc_rst_o[i] falls -> each mc_rst_o bit is high exactly 8 cycles, channels are sequenced in order 0..3, done=1, ch_ready=4'hF, all_ready=1, ch_fail=0.
2. Retry then pass: channel 1 calibrates only on its third attempt -> mc_rst_o[1] pulses 3 times; ch_ready[1]=1, ch_fail[1]=0; channels 2 and 3 proceed normally.
3. Exhausted retries: channel 2 never calibrates -> 3 timeouts of 64 cycles each, ch_fail=4'h4, mc_rst_o[2]=1 at done, ch_ready=4'hB, all_ready=0.
4. Calibration lost: in DONE, drop calib_done_i[3] for 1 cycle -> ch_ready[3]=0 and calib_lost[3]=1 and both persist after the input recovers; all_ready=0.
5. Restart and ignored start: pulse start while busy -> no effect. Pulse start in DONE -> mc_rst_o=4'hF, status cleared, full sequence repeats.
6. Reset mid-sequence: assert aresetn=0 during WAIT_CAL of channel 1 -> outputs immediately return to reset values (mc_rst_o=4'hF, busy=0). On release the sequence restarts at channel 0.
7. Simultaneous events: calib_done_i rises in the same cycle the timeout would fire -> channel is marked ready and no retry occurs.
